sharp_line_feeder: RTL and testbench

Upstream stage of the LS013B7DH01 SPI driver. On a frame request it reads the frame buffer byte-by-byte from a synchronous RAM port. It assembles each 144-pixel gate line and hands the driver one line at a time over a valid/ready handshake, together with the 1-based gate line address and the VCOM level to encode in the mode byte. It runs on the same 12 MHz system clock as the driver.

---
 rtl/sharp_line_feeder.sv | 156 +++++++++++++++
 tb/tb_sharp_line_feeder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sharp_line_feeder.sv
// Frame-buffer reader that assembles gate lines for the LS013B7DH01 SPI driver.
// Optional LINE_SKIP_EN adds a per-line dirty mask so clean lines are skipped without memory reads.
module sharp_line_feeder #(
  parameter int LINES      = 168,
  parameter int LINE_BYTES = 18,
  parameter int ADDR_W     = 12
) (
  input  logic                    clk_12mhz,
  input  logic                    rst_n,
  input  logic                    frame_start,
  output logic                    busy,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [7:0]              mem_rdata,
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic [7:0]              line_addr,
  output logic [8*LINE_BYTES-1:0] line_data,
  output logic                    vcom,
  output logic                    frame_done
`ifdef LINE_SKIP_EN
  ,
  input  logic                    mark_dirty,
  input  logic [7:0]              mark_line
`endif
);

  localparam int                BI_W      = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(LINE_BYTES);
  localparam logic [7:0]        LAST_LINE = 8'(LINES - 1);
  localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

  state_t            state;
  logic [7:0]        line_index;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] next_base;
  logic [BI_W-1:0]   byte_index;
  logic [BI_W-1:0]   cap_index;
  logic              cap_vld;
  logic              first_dirty;
  logic              next_dirty;

  assign next_base = base + STRIDE;

`ifdef LINE_SKIP_EN
  logic [LINES-1:0] dirty;
  logic             mark_ok;
  logic [7:0]       mark_idx;

  assign mark_ok     = mark_dirty && (mark_line != 8'd0) && (32'(mark_line) <= LINES);
  assign mark_idx    = mark_line - 8'd1;
  assign first_dirty = dirty[0];
  // Only consulted when line_index is not the last line, so the index stays in range.
  assign next_dirty  = dirty[line_index + 8'd1];

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= '1;
    end else begin
      if (state == PRESENT && line_ready) dirty[line_index] <= 1'b0;
      // Later assignment wins: a mark on the transfer edge keeps the line dirty.
      if (mark_ok) dirty[mark_idx] <= 1'b1;
    end
  end
`else
  assign first_dirty = 1'b1;
  assign next_dirty  = 1'b1;
`endif

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      line_valid <= 1'b0;
      line_addr  <= '0;
      line_data  <= '0;
      vcom       <= 1'b0;
      frame_done <= 1'b0;
      line_index <= '0;
      base       <= '0;
      byte_index <= '0;
      cap_index  <= '0;
      cap_vld    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cap_vld    <= mem_rd;
      cap_index  <= byte_index;
      if (cap_vld) line_data[8*LINE_BYTES-1-8*int'(cap_index) -: 8] <= mem_rdata;

      case (state)
        IDLE: begin
          if (frame_start && !frame_done) begin
            state      <= FETCH;
            busy       <= 1'b1;
            line_index <= '0;
            base       <= '0;
            mem_addr   <= '0;
            byte_index <= '0;
            mem_rd     <= first_dirty;
          end
        end
        FETCH: begin
          if (!mem_rd) begin
            // Clean line: spend this cycle stepping to the next line.
            if (line_index == LAST_LINE) begin
              state <= DONE;
            end else begin
              line_index <= line_index + 8'd1;
              base       <= next_base;
              mem_addr   <= next_base;
              mem_rd     <= next_dirty;
            end
          end else if (byte_index == LAST_BYTE) begin
            mem_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            byte_index <= byte_index + BI_W'(1);
            mem_addr   <= mem_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state      <= PRESENT;
          line_valid <= 1'b1;
          line_addr  <= line_index + 8'd1;
        end
        PRESENT: begin
          if (line_ready) begin
            line_valid <= 1'b0;
            if (line_index == LAST_LINE) begin
              state <= DONE;
            end else begin
              state      <= FETCH;
              line_index <= line_index + 8'd1;
              base       <= next_base;
              mem_addr   <= next_base;
              byte_index <= '0;
              mem_rd     <= next_dirty;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
          vcom       <= ~vcom;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sharp_line_feeder.sv
// Directed bench for sharp_line_feeder; memory returns the low byte of each address.
module tb_sharp_line_feeder;

  localparam int LINES = 168;
  localparam int LB    = 18;

  logic            clk_12mhz = 1'b0;
  logic            rst_n;
  logic            frame_start;
  logic            busy;
  logic            mem_rd;
  logic [11:0]     mem_addr;
  logic [7:0]      mem_rdata = 8'd0;
  logic            line_valid;
  logic            line_ready;
  logic [7:0]      line_addr;
  logic [8*LB-1:0] line_data;
  logic            vcom;
  logic            frame_done;
`ifdef LINE_SKIP_EN
  logic            mark_dirty;
  logic [7:0]      mark_line;
  int              remark_line;
`endif

  int tests = 0;
  int fails = 0;
  logic exp_vcom = 1'b0;

  int              n_xfer, rd_cnt, post_rd, post_lv, first_rd_cyc, first_lv_cyc, fd_cnt, fd_cyc, after;
  logic [11:0]     first_rd_addr, max_addr;
  logic            busy_at_fd, vcom_at_fd;
  logic [7:0]      xa[$];
  logic [8*LB-1:0] xd[$];

  sharp_line_feeder #(.LINES(LINES), .LINE_BYTES(LB), .ADDR_W(12)) dut (
    .clk_12mhz  (clk_12mhz),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .busy       (busy),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_addr  (line_addr),
    .line_data  (line_data),
    .vcom       (vcom),
    .frame_done (frame_done)
`ifdef LINE_SKIP_EN
    ,
    .mark_dirty (mark_dirty),
    .mark_line  (mark_line)
`endif
  );

  always #5 clk_12mhz = ~clk_12mhz;

  always @(posedge clk_12mhz) if (mem_rd) mem_rdata <= mem_addr[7:0];

  function automatic logic [8*LB-1:0] exp_line(input int idx);
    logic [8*LB-1:0] v;
    v = '0;
    for (int k = 0; k < LB; k++) v[8*LB-1-8*k -: 8] = 8'((idx * LB + k) & 255);
    return v;
  endfunction

  // Runs one frame with line_ready high and records what the DUT produced.
  task automatic run_frame(input bit poke);
    n_xfer = 0; rd_cnt = 0; post_rd = 0; post_lv = 0; fd_cnt = 0; after = 0;
    first_rd_cyc = -1; first_lv_cyc = -1; fd_cyc = -1;
    first_rd_addr = '0; max_addr = '0; busy_at_fd = 1'b1; vcom_at_fd = 1'b0;
    xa.delete(); xd.delete();
    line_ready = 1'b1;
    frame_start = 1'b1;
    for (int t = 1; t <= 4000; t++) begin
      @(posedge clk_12mhz); #1;
      frame_start = 1'b0;
`ifdef LINE_SKIP_EN
      mark_dirty = 1'b0;
`endif
      if (poke && (t == 50 || t == 500)) frame_start = 1'b1;
      if (mem_rd) begin
        if (fd_cnt == 0) rd_cnt++; else post_rd++;
        if (first_rd_cyc < 0) begin first_rd_cyc = t; first_rd_addr = mem_addr; end
        if (mem_addr > max_addr) max_addr = mem_addr;
      end
      if (line_valid) begin
        if (fd_cnt > 0) post_lv++;
        if (first_lv_cyc < 0) first_lv_cyc = t;
        if (line_ready) begin
          xa.push_back(line_addr); xd.push_back(line_data); n_xfer++;
`ifdef LINE_SKIP_EN
          if (remark_line != 0 && int'(line_addr) == remark_line) begin
            mark_dirty = 1'b1; mark_line = 8'(remark_line);
          end
`endif
        end
      end
      if (frame_done) begin
        fd_cnt++;
        if (fd_cyc < 0) begin fd_cyc = t; busy_at_fd = busy; vcom_at_fd = vcom; end
        if (poke) frame_start = 1'b1;
      end
      if (fd_cnt > 0) begin
        after++;
        if (after > 30) break;
      end
    end
    frame_start = 1'b0;
`ifdef LINE_SKIP_EN
    mark_dirty = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b1; frame_start = 1'b0; line_ready = 1'b0;
`ifdef LINE_SKIP_EN
    mark_dirty = 1'b0; mark_line = 8'd0; remark_line = 0;
`endif
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk_12mhz);
    #1;
    tests++;
    if ({busy, mem_rd, mem_addr, line_valid, line_addr, line_data, vcom, frame_done} !== '0)
      $display("FAIL reset_outputs: got busy=%b rd=%b addr=%0d lv=%b la=%0d vcom=%b fd=%b, all must be 0",
               busy, mem_rd, mem_addr, line_valid, line_addr, vcom, frame_done);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk_12mhz);
    #1;
    tests++;
    if ({busy, mem_rd, mem_addr, line_valid, line_addr, line_data, vcom, frame_done} !== '0)
      $display("FAIL idle_after_reset: got busy=%b rd=%b lv=%b fd=%b, all must be 0", busy, mem_rd, line_valid, frame_done);
  endtask

  task automatic test_full_frame();
    int bad;
    bad = 0;
    run_frame(1'b0);
    exp_vcom = ~exp_vcom;
    tests++; if (fd_cnt !== 1) begin fails++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
    tests++; if (fd_cyc !== 3362) begin fails++; $display("FAIL frame_done_cycle: got %0d want 3362", fd_cyc); end
    tests++; if (busy_at_fd !== 1'b0) begin fails++; $display("FAIL busy_at_done: got %b want 0", busy_at_fd); end
    tests++; if (vcom_at_fd !== 1'b1) begin fails++; $display("FAIL vcom_first_frame: got %b want 1", vcom_at_fd); end
    tests++; if (first_rd_cyc !== 1 || first_rd_addr !== 12'd0) begin
      fails++; $display("FAIL first_read: got cycle %0d addr %0d want cycle 1 addr 0", first_rd_cyc, first_rd_addr); end
    tests++; if (first_lv_cyc !== 20) begin fails++; $display("FAIL first_line_valid: got %0d want 20", first_lv_cyc); end
    tests++; if (rd_cnt !== LINES * LB) begin fails++; $display("FAIL read_count: got %0d want %0d", rd_cnt, LINES * LB); end
    tests++; if (max_addr !== 12'd3023) begin fails++; $display("FAIL max_addr: got %0d want 3023", max_addr); end
    tests++; if (n_xfer !== LINES) begin fails++; $display("FAIL line_count: got %0d want %0d", n_xfer, LINES); end
    for (int i = 0; i < n_xfer && i < LINES; i++)
      if (xa[i] !== 8'(i + 1) || xd[i] !== exp_line(i)) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL line_contents: got %0d bad lines want 0", bad); end
    tests++; if (xd.size() < 1 || xd[0] !== 144'h000102030405060708090a0b0c0d0e0f1011) begin
      fails++; $display("FAIL line1_data: got %h want 000102030405060708090a0b0c0d0e0f1011", xd.size() > 0 ? xd[0] : '0); end
    tests++; if (xd.size() < LINES || xd[LINES-1] !== exp_line(LINES - 1)) begin
      fails++; $display("FAIL line168_data: got %h want %h", xd.size() >= LINES ? xd[LINES-1] : '0, exp_line(LINES - 1)); end
    tests++; if (post_rd !== 0 || post_lv !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL quiet_after_frame: got rd=%0d lv=%0d busy=%b want 0 0 0", post_rd, post_lv, busy); end
  endtask

  task automatic test_stall();
    int phase, hold, unstable, rd_during, nx, fdc;
    bit post_ok;
    phase = 0; hold = 0; unstable = 0; rd_during = 0; nx = 0; fdc = -1; post_ok = 1'b0;
    line_ready = 1'b1; frame_start = 1'b1;
    for (int t = 1; t <= 5000; t++) begin
      @(posedge clk_12mhz); #1;
      frame_start = 1'b0;
      if (phase == 2) begin
        post_ok = (line_valid === 1'b0 && mem_rd === 1'b1 && mem_addr === 12'd90);
        phase = 3;
      end else if (phase == 1) begin
        hold++;
        if (line_valid !== 1'b1 || line_addr !== 8'd5 || line_data !== exp_line(4)) unstable++;
        if (mem_rd) rd_during++;
        if (hold == 50) begin line_ready = 1'b1; phase = 2; end
      end
      if (phase == 0 && line_valid && line_addr == 8'd5) begin line_ready = 1'b0; phase = 1; end
      if (line_valid && line_ready) nx++;
      if (frame_done) begin fdc = t; break; end
    end
    line_ready = 1'b1;
    exp_vcom = ~exp_vcom;
    tests++; if (unstable !== 0) begin fails++; $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); end
    tests++; if (rd_during !== 0) begin fails++; $display("FAIL stall_no_read: got %0d reads want 0", rd_during); end
    tests++; if (post_ok !== 1'b1) begin fails++; $display("FAIL stall_resume: got %b want 1 (lv=0, rd=1, addr 90)", post_ok); end
    tests++; if (nx !== LINES) begin fails++; $display("FAIL stall_line_count: got %0d want %0d", nx, LINES); end
    tests++; if (fdc !== 3412) begin fails++; $display("FAIL stall_done_cycle: got %0d want 3412", fdc); end
    tests++; if (vcom !== exp_vcom) begin fails++; $display("FAIL stall_vcom: got %b want %b", vcom, exp_vcom); end
  endtask

  task automatic test_busy_ignored();
    run_frame(1'b1);
    exp_vcom = ~exp_vcom;
    tests++; if (fd_cnt !== 1 || n_xfer !== LINES) begin
      fails++; $display("FAIL busy_ignore_counts: got done=%0d lines=%0d want 1 %0d", fd_cnt, n_xfer, LINES); end
    tests++; if (post_rd !== 0 || post_lv !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL coincident_start: got rd=%0d lv=%0d busy=%b want 0 0 0", post_rd, post_lv, busy); end
    tests++; if (vcom_at_fd !== exp_vcom) begin fails++; $display("FAIL busy_vcom: got %b want %b", vcom_at_fd, exp_vcom); end
    run_frame(1'b0);
    exp_vcom = ~exp_vcom;
    tests++; if (vcom_at_fd !== 1'b0 || vcom_at_fd !== exp_vcom || n_xfer !== LINES) begin
      fails++; $display("FAIL second_frame: got vcom=%b lines=%0d want 0 %0d", vcom_at_fd, n_xfer, LINES); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    int idle_bad;
    hit = 1'b0; idle_bad = 0;
    line_ready = 1'b1; frame_start = 1'b1;
    for (int t = 1; t <= 2000; t++) begin
      @(posedge clk_12mhz); #1;
      frame_start = 1'b0;
      if (mem_rd && mem_addr == 12'd705) begin hit = 1'b1; break; end
    end
    tests++; if (hit !== 1'b1 || line_addr !== 8'd39) begin
      fails++; $display("FAIL reach_line40: got hit=%b line_addr=%0d want 1 39", hit, line_addr); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, mem_rd, mem_addr, line_valid, line_addr, line_data, vcom, frame_done} !== '0) begin
      fails++; $display("FAIL async_reset: got busy=%b rd=%b addr=%0d lv=%b la=%0d vcom=%b want all 0",
                        busy, mem_rd, mem_addr, line_valid, line_addr, vcom); end
    repeat (3) @(posedge clk_12mhz);
    #3 rst_n = 1'b1;
    exp_vcom = 1'b0;
    repeat (5) begin
      @(posedge clk_12mhz); #1;
      if (busy !== 1'b0 || line_valid !== 1'b0 || mem_rd !== 1'b0) idle_bad++;
    end
    tests++; if (idle_bad !== 0) begin fails++; $display("FAIL idle_after_release: got %0d active cycles want 0", idle_bad); end
    run_frame(1'b0);
    exp_vcom = ~exp_vcom;
    tests++; if (first_rd_cyc !== 1 || first_rd_addr !== 12'd0 || xa.size() < 1 || xa[0] !== 8'd1) begin
      fails++; $display("FAIL restart_from_line1: got cycle %0d addr %0d first line %0d want 1 0 1",
                        first_rd_cyc, first_rd_addr, xa.size() > 0 ? xa[0] : 8'd0); end
    tests++; if (n_xfer !== LINES || vcom_at_fd !== exp_vcom) begin
      fails++; $display("FAIL restart_frame: got lines=%0d vcom=%b want %0d %b", n_xfer, vcom_at_fd, LINES, exp_vcom); end
  endtask

`ifdef LINE_SKIP_EN
  task automatic test_skip_marked();
    mark_dirty = 1'b1;
    mark_line = 8'd3;   @(posedge clk_12mhz); #1;
    mark_line = 8'd168; @(posedge clk_12mhz); #1;
    mark_line = 8'd0;   @(posedge clk_12mhz); #1;
    mark_line = 8'd169; @(posedge clk_12mhz); #1;
    mark_dirty = 1'b0;
    remark_line = 3;
    run_frame(1'b0);
    remark_line = 0;
    exp_vcom = ~exp_vcom;
    tests++; if (n_xfer !== 2 || xa[0] !== 8'd3 || xa[1] !== 8'd168) begin
      fails++; $display("FAIL skip_addrs: got %0d lines first=%0d second=%0d want 2 lines 3 168",
                        n_xfer, xa.size() > 0 ? xa[0] : 8'd0, xa.size() > 1 ? xa[1] : 8'd0); end
    tests++; if (xd.size() < 2 || xd[0] !== exp_line(2) || xd[1] !== exp_line(167)) begin
      fails++; $display("FAIL skip_data: got %h want %h", xd.size() > 0 ? xd[0] : '0, exp_line(2)); end
    tests++; if (fd_cnt !== 1 || vcom_at_fd !== exp_vcom) begin
      fails++; $display("FAIL skip_done: got done=%0d vcom=%b want 1 %b", fd_cnt, vcom_at_fd, exp_vcom); end
    run_frame(1'b0);
    exp_vcom = ~exp_vcom;
    tests++; if (n_xfer !== 1 || xa[0] !== 8'd3) begin
      fails++; $display("FAIL remark_wins: got %0d lines first=%0d want 1 line 3", n_xfer, xa.size() > 0 ? xa[0] : 8'd0); end
  endtask

  task automatic test_skip_none();
    run_frame(1'b0);
    exp_vcom = ~exp_vcom;
    tests++; if (n_xfer !== 0 || first_lv_cyc !== -1 || rd_cnt !== 0) begin
      fails++; $display("FAIL clean_frame_lines: got lines=%0d lv_cycle=%0d reads=%0d want 0 -1 0", n_xfer, first_lv_cyc, rd_cnt); end
    tests++; if (fd_cnt !== 1 || vcom_at_fd !== exp_vcom) begin
      fails++; $display("FAIL clean_frame_done: got done=%0d vcom=%b want 1 %b", fd_cnt, vcom_at_fd, exp_vcom); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_busy_ignored();
    test_reset_mid();
`ifdef LINE_SKIP_EN
    test_skip_marked();
    test_skip_none();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
